// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time parameter checks for the synchronous FIFO.
package fifo_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_AF_THRESH = 12;
   localparam int DEF_AE_THRESH = 4;
   localparam int DEF_FWFT      = 0;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit data_w_ok(input int data_w);
      return (data_w >= 1) && (data_w <= 64);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 4) && (depth <= 1024) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit thresh_ok(input int depth, input int af, input int ae);
      return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
   endfunction

   function automatic bit fwft_ok(input int fwft);
      return (fwft == 0) || (fwft == 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one read port that is either
// registered (FWFT=0) or combinational (FWFT=1). The array itself is never reset.
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int FWFT   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data = mem_q[rd_addr];
      end else begin : g_reg
         logic [DATA_W-1:0] rd_data_q;
         logic [DATA_W-1:0] rd_data_d;

         // Only the output register clears; it holds its word until the next accepted pop.
         always_comb begin
            rd_data_d = rd_data_q;
            if (rd_en) begin
               rd_data_d = mem_q[rd_addr];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_q <= '0;
            end else begin
               rd_data_q <= rd_data_d;
            end
         end

         assign rd_data = rd_data_q;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, level/threshold flags and
// one-cycle overflow/underflow pulses on rejected requests.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEF_AF_THRESH,
   parameter int AE_THRESH = DEF_AE_THRESH,
   parameter int FWFT      = DEF_FWFT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [clog2(DEPTH):0]  level,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int ADDR_W = clog2(DEPTH);

   generate
      if (!(data_w_ok(DATA_W) && depth_ok(DEPTH) && thresh_ok(DEPTH, AF_THRESH, AE_THRESH)
            && fwft_ok(FWFT))) begin : g_param_err
         $fatal(1, "sync_fifo: illegal parameter combination");
      end
   endgenerate

   localparam int          AF_INT = AF_THRESH;
   localparam int          AE_INT = AE_THRESH;
   localparam logic [ADDR_W:0] AF_LVL = AF_INT[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_LVL = AE_INT[ADDR_W:0];

   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;
   logic            wr_acc;
   logic            rd_acc;

   // Flags come straight from the registered pointers; the extra MSB tells full from empty.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                         (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign level        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (level >= AF_LVL);
   assign almost_empty = (level <= AE_LVL);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_acc      = wr_en && !full;
      rd_acc      = rd_en && !empty;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .FWFT   (FWFT)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: registered-read instance for the main traffic,
// plus a first-word-fall-through instance for the fall-through behaviour.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] level;

   logic       f_wr_en = 1'b0;
   logic [7:0] f_wr_data = 8'h00;
   logic       f_rd_en = 1'b0;
   logic [7:0] f_rd_data;
   logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
   logic [4:0] f_level;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       rd_fire = 1'b0;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
      .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
      .almost_empty(f_almost_empty), .level(f_level), .overflow(f_overflow),
      .underflow(f_underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the queue model predicts acceptance from pre-edge occupancy.
   task automatic cycle(input logic w, input logic [7:0] d, input logic r);
      logic pre_full, pre_empty, exp_ovf, exp_udf;
      int   sz;
      @(negedge clk);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      pre_full  = (mq.size() == 16);
      pre_empty = (mq.size() == 0);
      exp_ovf   = w && pre_full;
      exp_udf   = r && pre_empty;
      if (r && !pre_empty) begin
         exp_q.push_back(mq.pop_front());
         rd_fire = 1'b1;
      end else begin
         rd_fire = 1'b0;
      end
      if (w && !pre_full) mq.push_back(d);
      @(posedge clk);
      #1;
      sz = mq.size();
      chk("level", 32'(level), 32'(sz));
      chk("full", 32'(full), 32'(sz == 16));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= 12));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= 4));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("underflow", 32'(underflow), 32'(exp_udf));
   endtask

   // Monitor: every edge at which a pop was accepted owes one word on rd_data.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         if (rd_fire) begin
            #2;
            if (exp_q.size() == 0) begin
               chk("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 32'(rd_data), 32'(e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ae", 32'(almost_empty), 32'd1);
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_udf", 32'(underflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Fill 0x00..0x0F, then one rejected write
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
      chk("full_level16", 32'(level), 32'd16);
      cycle(1'b1, 8'hFF, 1'b0);
      chk("ovf_level_held", 32'(level), 32'd16);
      cycle(1'b0, 8'h00, 1'b0);

      // Drain, then one rejected read; output must hold the last word
      for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("rd_hold_0F", 32'(rd_data), 32'h0F);
      cycle(1'b0, 8'h00, 1'b0);

      // Simultaneous request at empty and at full
      cycle(1'b1, 8'h55, 1'b1);
      chk("empty_both_level1", 32'(level), 32'd1);
      cycle(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
      cycle(1'b1, 8'hEE, 1'b1);
      chk("full_both_level15", 32'(level), 32'd15);
      for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);

      // Steady state at level 8 across two pointer wraps
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
      chk("steady_level8", 32'(level), 32'd8);
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Asynchronous reset with 9 words stored
      for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
      @(negedge clk);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      rd_fire = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
      chk("mid_rst_full", 32'(full), 32'd0);
      mq.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      chk("all_reads_seen", 32'(exp_q.size()), 32'd0);

      // First-word-fall-through instance
      chk("fwft_empty_init", 32'(f_empty), 32'd1);
      @(negedge clk);
      f_wr_en   = 1'b1;
      f_wr_data = 8'hA5;
      @(negedge clk);
      f_wr_en = 1'b0;
      chk("fwft_rd_data", 32'(f_rd_data), 32'hA5);
      chk("fwft_level1", 32'(f_level), 32'd1);
      chk("fwft_not_empty", 32'(f_empty), 32'd0);
      f_rd_en = 1'b1;
      @(posedge clk);
      #1;
      chk("fwft_pop_empty", 32'(f_empty), 32'd1);
      chk("fwft_pop_udf", 32'(f_underflow), 32'd0);
      @(negedge clk);
      f_rd_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
